fpu_share_arbiter: RTL and testbench
====================================

// Module: fpu_share_arbiter
// PURPOSE
//  Round-robin arbiter that time-shares one double_divider/double_multiplier/double_adder
//  instance among N_REQ requesters (e.g. LU decomposition row lanes).
//  Each requester gets its own stb/ack operand port and stb/ack result port.
//  The arbiter drives the shared unit's stb/ack handshake and returns each result
//  only to the requester that issued it.
//  One operation is in flight at a time.
// PARAMETERS
//  N_REQ  3   number of requesters, 2..4
//  WIDTH  64  operand/result width (IEEE-754 double)
//  SEL_W  2   width of grant index, must be >= clog2(N_REQ)
// PORTS
//  clk          in   1            clock; all logic on posedge
//  rst          in   1            synchronous, active-high reset
//  req_a        in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   N_REQ*WIDTH  operand B, same packing
//  req_stb      in   N_REQ        requester i has valid operands
//  req_ack      out  N_REQ        one-cycle pulse: operands of requester i captured
//  resp_z       out  WIDTH        result, valid for the granted requester while resp_stb high
//  resp_stb     out  N_REQ        result ready for requester i, held until resp_ack[i]
//  resp_ack     in   N_REQ        requester i accepts result
//  unit_a       out  WIDTH        to shared unit input_a
//  unit_b       out  WIDTH        to shared unit input_b
//  unit_a_stb   out  1            to input_a_stb
//  unit_b_stb   out  1            to input_b_stb
//  unit_a_ack   in   1            from input_a_ack
//  unit_b_ack   in   1            from input_b_ack
//  unit_z       in   WIDTH        from output_z
//  unit_z_stb   in   1            from output_z_stb
//  unit_z_ack   out  1            to output_z_ack
//  busy         out  1            high in every state except IDLE
//  grant        out  SEL_W        index of current/last served requester
// BEHAVIOUR
//  Reset: every output is 0. State = IDLE. Round-robin pointer last = N_REQ-1, so requester 0 wins first.
//  The shared unit shares clk/rst with the arbiter. An op aborted by reset is discarded; no req_ack or resp_stb is issued for it.
//  FSM (all outputs registered):
//   IDLE:  if |req_stb, pick first i with req_stb[i] searching last+1, last+2, ... mod N_REQ.
//          Capture req_a[i], req_b[i] into unit_a/unit_b; grant<=i; req_ack[i]<=1 (1 cycle);
//          unit_a_stb<=1; unit_b_stb<=1; busy<=1; -> ISSUE. Otherwise stay.
//   ISSUE: req_ack<=0. unit_a_stb drops the cycle after unit_a_ack&&unit_a_stb is sampled high; unit_b_stb likewise.
//          A and B may be acked in different cycles.
//          When both strobes have been accepted -> WAIT_Z.
//   WAIT_Z: on unit_z_stb: resp_z<=unit_z; resp_stb[grant]<=1; unit_z_ack<=1 (1 cycle) -> RESP.
//   RESP:  unit_z_ack<=0. Hold resp_stb[grant] and resp_z until resp_ack[grant] is sampled high,
//          then resp_stb<=0, last<=grant, busy<=0 -> IDLE.
//  Latency: req_stb high in IDLE -> unit strobes high 1 cycle later. Min issue-to-issue gap is
//   unit latency + 4 cycles.
//  Requesters must drop req_stb the cycle req_ack is seen and hold operands stable until then.
//   req_stb of any requester is ignored outside IDLE.
//  A requester dropping req_stb before grant is legal; nothing is latched for it.
//  resp_ack of a non-granted requester, or outside RESP, is ignored.
//  unit_z_stb outside WAIT_Z is ignored. The unit never produces one, since only one op is in flight.
//  Fairness: with all N_REQ requesting continuously, grants cycle 0,1,2,0,...; no requester waits more than N_REQ-1 ops.
//  grant holds its value in IDLE; busy==0 exactly in IDLE.
// TESTING
//  (Unit = double_divider, N_REQ=3)
//  1 Single req: req0 a=0x4008000000000000 (3.0), b=0x3FF8000000000000 (1.5)
//    -> req_ack[0] 1 cycle later; resp_stb[0] with resp_z=0x4000000000000000 (2.0); grant=0.
//  2 All three req_stb high from reset -> service order 0,1,2, then 0 again with req0 re-asserted.
//    Each resp_stb is routed only to its requester with its own quotient.
//  3 resp_ack[1] withheld 20 cycles -> resp_stb[1]/resp_z stable; busy=1; no new unit_a_stb until ack.
//    Pending req2 is issued the cycle after IDLE is re-entered.
//  4 Stub unit acks A in cycle t and B in t+3 -> unit_a_stb low from t+1, unit_b_stb low from t+4;
//    WAIT_Z entered once, no duplicate issue.
//  5 rst pulsed while in WAIT_Z -> all outputs 0 next cycle; no resp_stb for the aborted op.
//    Next req2-only request is granted (pointer reset: requester 0 preferred, 2 wins if alone).
//  6 Spurious resp_ack[2] and req_stb[0] during RESP for req1 -> ignored; no extra req_ack; grant stays 1.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
// Round-robin arbiter that lets N_REQ requesters share one floating-point unit
// (divider, multiplier or adder) through stb/ack handshakes. Only one operation
// is in flight at a time. The result goes back only to the requester that
// issued the operation. All outputs are registered.

module fpu_share_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 64,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_stb,
  output logic [N_REQ-1:0]       req_ack,
  output logic [WIDTH-1:0]       resp_z,
  output logic [N_REQ-1:0]       resp_stb,
  input  logic [N_REQ-1:0]       resp_ack,
  output logic [WIDTH-1:0]       unit_a,
  output logic [WIDTH-1:0]       unit_b,
  output logic                   unit_a_stb,
  output logic                   unit_b_stb,
  input  logic                   unit_a_ack,
  input  logic                   unit_b_ack,
  input  logic [WIDTH-1:0]       unit_z,
  input  logic                   unit_z_stb,
  output logic                   unit_z_ack,
  output logic                   busy,
  output logic [SEL_W-1:0]       grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_Z = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Pointer value after reset is the last requester, so requester 0 wins first.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);

  state_e             state_q,      state_d;
  logic [SEL_W-1:0]   last_q,       last_d;
  logic [SEL_W-1:0]   grant_q,      grant_d;
  logic [N_REQ-1:0]   req_ack_q,    req_ack_d;
  logic [N_REQ-1:0]   resp_stb_q,   resp_stb_d;
  logic [WIDTH-1:0]   resp_z_q,     resp_z_d;
  logic [WIDTH-1:0]   unit_a_q,     unit_a_d;
  logic [WIDTH-1:0]   unit_b_q,     unit_b_d;
  logic               unit_a_stb_q, unit_a_stb_d;
  logic               unit_b_stb_q, unit_b_stb_d;
  logic               unit_z_ack_q, unit_z_ack_d;
  logic               busy_q,       busy_d;

  logic               pick_vld;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   cand;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   grant_oh;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               a_done;
  logic               b_done;
  logic               resp_ack_g;

  // Round-robin search from last+1 upward; scanning the distance downward lets
  // the nearest requesting index overwrite the farther ones.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = SEL_W'((int'(last_q) + k) % N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (req_stb[i] && (cand == SEL_W'(i))) begin
          pick_vld = 1'b1;
          pick_idx = cand;
        end
      end
    end
  end

  // One-hot decode of the pick and the grant, plus the operand mux for the pick.
  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == SEL_W'(i)) begin
        pick_oh[i] = 1'b1;
        sel_a      = req_a[i*WIDTH +: WIDTH];
        sel_b      = req_b[i*WIDTH +: WIDTH];
      end
      grant_oh[i] = (grant_q == SEL_W'(i));
    end
  end

  // A strobe counts as accepted if it is already low or is acked this cycle.
  assign a_done     = ~unit_a_stb_q | unit_a_ack;
  assign b_done     = ~unit_b_stb_q | unit_b_ack;
  // Only the owner of the result can release it.
  assign resp_ack_g = |(resp_ack & grant_oh);

  // Next-state and next-output logic for the issue / wait / respond sequence.
  always_comb begin
    // NOTE: every _d starts from its _q, so no path through the case leaves a
    // signal unassigned and no latch is inferred.
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    req_ack_d    = req_ack_q;
    resp_stb_d   = resp_stb_q;
    resp_z_d     = resp_z_q;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    unit_a_stb_d = unit_a_stb_q;
    unit_b_stb_d = unit_b_stb_q;
    unit_z_ack_d = unit_z_ack_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          unit_a_d     = sel_a;
          unit_b_d     = sel_b;
          grant_d      = pick_idx;
          req_ack_d    = pick_oh;
          unit_a_stb_d = 1'b1;
          unit_b_stb_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_ack_d = '0;
        if (unit_a_stb_q && unit_a_ack) unit_a_stb_d = 1'b0;
        if (unit_b_stb_q && unit_b_ack) unit_b_stb_d = 1'b0;
        if (a_done && b_done) state_d = S_WAIT_Z;
      end
      S_WAIT_Z: begin
        if (unit_z_stb) begin
          resp_z_d     = unit_z;
          resp_stb_d   = grant_oh;
          unit_z_ack_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        unit_z_ack_d = 1'b0;
        if (resp_ack_g) begin
          resp_stb_d = '0;
          last_d     = grant_q;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and result registers are reset as well, because every
      // output, data included, must read 0 right after reset.
      state_q      <= S_IDLE;
      last_q       <= LAST_RST;
      grant_q      <= '0;
      req_ack_q    <= '0;
      resp_stb_q   <= '0;
      resp_z_q     <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      unit_a_stb_q <= 1'b0;
      unit_b_stb_q <= 1'b0;
      unit_z_ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop takes the value its _d had
      // before this edge regardless of statement order.
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      req_ack_q    <= req_ack_d;
      resp_stb_q   <= resp_stb_d;
      resp_z_q     <= resp_z_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      unit_a_stb_q <= unit_a_stb_d;
      unit_b_stb_q <= unit_b_stb_d;
      unit_z_ack_q <= unit_z_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign resp_stb   = resp_stb_q;
  assign resp_z     = resp_z_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign unit_a_stb = unit_a_stb_q;
  assign unit_b_stb = unit_b_stb_q;
  assign unit_z_ack = unit_z_ack_q;
  assign busy       = busy_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Testbench for fpu_share_arbiter: randomized requester agents and a stub
// divider drive the arbiter; a transaction-level reference model predicts
// every registered output each cycle.

module tb_fpu_share_arbiter;

  localparam int N  = 3;
  localparam int W  = 64;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, resp_stb, resp_ack;
  logic [W-1:0]    resp_z, unit_a, unit_b, unit_z;
  logic            unit_a_stb, unit_b_stb, unit_a_ack, unit_b_ack;
  logic            unit_z_stb, unit_z_ack, busy;
  logic [SW-1:0]   grant;

  always #5 clk = ~clk;

  fpu_share_arbiter #(.N_REQ(N), .WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb),
    .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack),
    .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
    .busy(busy), .grant(grant)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  // Reference model: one op outstanding, phases tracked as simple flags.
  bit          m_busy, m_a_pend, m_b_pend, m_waitz, m_resp;
  int          m_grant, m_last;
  logic [W-1:0] m_z, m_opa, m_opb;
  int          grant_log[$];

  // Requester agents.
  int          ag_st[N], ag_ops[N], ag_cnt[N], ag_dly[N];
  bit          ag_en[N];
  logic [W-1:0] ag_q[N], last_z[N];
  int          start_div, spur_div;
  bit          withdraw, fix0;

  // Stub unit.
  int          st_ph, st_ca, st_cb, st_cz, st_fa, st_fb, st_zmax;
  bit          st_ga, st_gb, st_fix;
  logic [W-1:0] st_a, st_b;

  int          a_hi, b_hi, hold1;

  task automatic model_check();
    logic [N-1:0] exp_ack, exp_rs;
    logic         exp_zack;
    int           pick, j;
    if (rst) begin
      m_busy = 0; m_a_pend = 0; m_b_pend = 0; m_waitz = 0; m_resp = 0;
      m_grant = 0; m_last = N - 1;
      check("rst_req_ack", 64'(req_ack), 64'd0);
      check("rst_resp_stb", 64'(resp_stb), 64'd0);
      check("rst_resp_z", resp_z, 64'd0);
      check("rst_unit_a", unit_a, 64'd0);
      check("rst_unit_b", unit_b, 64'd0);
      check("rst_stbs", 64'({unit_a_stb, unit_b_stb, unit_z_ack}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      return;
    end
    exp_ack  = '0;
    exp_zack = 1'b0;
    if (!m_busy) begin
      pick = -1;
      for (int k = 1; k <= N && pick < 0; k++) begin
        j = (m_last + k) % N;
        if (req_stb[j]) pick = j;
      end
      if (pick >= 0) begin
        m_busy = 1; m_grant = pick; exp_ack[pick] = 1'b1;
        m_a_pend = 1; m_b_pend = 1;
        m_opa = req_a[pick*W +: W];
        m_opb = req_b[pick*W +: W];
        grant_log.push_back(pick);
        check("issue_a", unit_a, m_opa);
        check("issue_b", unit_b, m_opb);
      end
    end else if (m_a_pend || m_b_pend) begin
      if (unit_a_ack) m_a_pend = 0;
      if (unit_b_ack) m_b_pend = 0;
      if (!m_a_pend && !m_b_pend) m_waitz = 1;
    end else if (m_waitz) begin
      if (unit_z_stb) begin
        m_waitz = 0; m_resp = 1; exp_zack = 1'b1; m_z = unit_z;
      end
    end else if (m_resp) begin
      if (resp_ack[m_grant]) begin
        m_resp = 0; m_busy = 0; m_last = m_grant;
      end
    end
    exp_rs = '0;
    if (m_resp) exp_rs[m_grant] = 1'b1;
    check("req_ack", 64'(req_ack), 64'(exp_ack));
    check("busy", 64'(busy), 64'(m_busy));
    check("unit_a_stb", 64'(unit_a_stb), 64'(m_a_pend));
    check("unit_b_stb", 64'(unit_b_stb), 64'(m_b_pend));
    check("unit_z_ack", 64'(unit_z_ack), 64'(exp_zack));
    check("resp_stb", 64'(resp_stb), 64'(exp_rs));
    check("grant", 64'(grant), 64'(m_grant));
    if (m_resp) check("resp_z_hold", resp_z, m_z);
  endtask

  function automatic bit spur();
    return (spur_div > 0) && ($urandom_range(spur_div - 1, 0) == 0);
  endfunction

  task automatic agents_update();
    logic [W-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      case (ag_st[i])
        0: begin
          resp_ack[i] = spur();
          if (ag_en[i] && ag_ops[i] > 0 && $urandom_range(start_div - 1, 0) == 0) begin
            a = $realtobits(real'($urandom_range(999, 1)));
            b = $realtobits(real'($urandom_range(999, 1)));
            if (i == 0 && fix0) begin
              a = 64'h4008000000000000;
              b = 64'h3FF8000000000000;
            end
            req_a[i*W +: W] = a;
            req_b[i*W +: W] = b;
            ag_q[i]    = fdiv(a, b);
            req_stb[i] = 1'b1;
            ag_st[i]   = 1;
          end
        end
        1: begin
          resp_ack[i] = spur();
          if (req_ack[i]) begin
            req_stb[i] = 1'b0; resp_ack[i] = 1'b0; ag_st[i] = 2; ag_cnt[i] = -1;
          end else if (withdraw && $urandom_range(11, 0) == 0) begin
            req_stb[i] = 1'b0; ag_st[i] = 0;
          end
        end
        2: begin
          resp_ack[i] = 1'b0;
          if (resp_stb[i]) begin
            if (ag_cnt[i] < 0) begin
              check($sformatf("resp_route%0d", i), resp_z, ag_q[i]);
              last_z[i] = resp_z;
              ag_cnt[i] = (ag_dly[i] >= 0) ? ag_dly[i] : int'($urandom_range(4, 0));
            end
            if (ag_cnt[i] == 0) begin
              resp_ack[i] = 1'b1; ag_st[i] = 3;
            end else ag_cnt[i]--;
          end
        end
        default: begin
          resp_ack[i] = 1'b0; ag_ops[i]--; ag_st[i] = 0;
        end
      endcase
    end
  endtask

  task automatic stub_update();
    case (st_ph)
      0: begin
        unit_a_ack = 1'b0;
        unit_b_ack = 1'b0;
        if (unit_a_stb && !st_ga) begin
          if (st_ca < 0) st_ca = st_fix ? st_fa : int'($urandom_range(3, 0));
          if (st_ca == 0) begin unit_a_ack = 1'b1; st_ga = 1; st_a = unit_a; end
          else st_ca--;
        end
        if (unit_b_stb && !st_gb) begin
          if (st_cb < 0) st_cb = st_fix ? st_fb : int'($urandom_range(3, 0));
          if (st_cb == 0) begin unit_b_ack = 1'b1; st_gb = 1; st_b = unit_b; end
          else st_cb--;
        end
        if (st_ga && st_gb && !unit_a_ack && !unit_b_ack) begin
          st_ph = 1; st_cz = int'($urandom_range(st_zmax, 1));
        end
      end
      1: begin
        if (st_cz == 0) begin
          unit_z_stb = 1'b1; unit_z = fdiv(st_a, st_b); st_ph = 2;
        end else st_cz--;
      end
      default: begin
        if (unit_z_ack) begin
          unit_z_stb = 1'b0; st_ph = 0; st_ga = 0; st_gb = 0; st_ca = -1; st_cb = -1;
        end
      end
    endcase
    if (!unit_z_stb) unit_z = {$urandom, $urandom};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_check();
    if (unit_a_stb) a_hi++;
    if (unit_b_stb) b_hi++;
    if (resp_stb[1]) hold1++;
    if (!rst) begin
      stub_update();
      agents_update();
    end
  endtask

  task automatic clear_tb();
    req_a = '0; req_b = '0; req_stb = '0; resp_ack = '0;
    unit_a_ack = 0; unit_b_ack = 0; unit_z_stb = 0; unit_z = '0;
    for (int i = 0; i < N; i++) begin
      ag_st[i] = 0; ag_ops[i] = 0; ag_cnt[i] = -1; ag_dly[i] = -1; ag_en[i] = 0;
      ag_q[i] = '0; last_z[i] = '0;
    end
    start_div = 1; spur_div = 0; withdraw = 0; fix0 = 0;
    st_ph = 0; st_ca = -1; st_cb = -1; st_cz = 0; st_ga = 0; st_gb = 0;
    st_fix = 0; st_fa = 0; st_fb = 0; st_zmax = 4;
    a_hi = 0; b_hi = 0; hold1 = 0;
    grant_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    step();
    rst = 1'b0;
  endtask

  function automatic bit all_done();
    bit d = !m_busy;
    for (int i = 0; i < N; i++) if (ag_st[i] != 0 || ag_ops[i] != 0) d = 0;
    return d;
  endfunction

  task automatic run(input string tag, input int maxc);
    int c = 0;
    while (!all_done() && c < maxc) begin
      step();
      c++;
    end
    check({tag, "_done"}, 64'(all_done()), 64'd1);
  endtask

  initial begin
    // 1: single request 3.0 / 1.5
    do_reset();
    ag_en[0] = 1; ag_ops[0] = 1; fix0 = 1;
    run("t1", 200);
    check("t1_result", last_z[0], 64'h4000000000000000);
    check("t1_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

    // 2: all three requesting from reset, round-robin order
    do_reset();
    for (int i = 0; i < N; i++) begin ag_en[i] = 1; ag_ops[i] = 2; end
    run("t2", 500);
    check("t2_nops", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2_order%0d", k), 64'(grant_log[k]), 64'(k % N));

    // 3: resp_ack[1] withheld 20 cycles while req2 waits
    do_reset();
    ag_en[1] = 1; ag_ops[1] = 1; ag_en[2] = 1; ag_ops[2] = 1; ag_dly[1] = 20;
    run("t3", 500);
    check("t3_hold_cycles", 64'(hold1), 64'd21);
    check("t3_order", 64'({grant_log[0], grant_log[1]}), {32'd1, 32'd2});

    // 4: A acked at once, B three cycles later
    do_reset();
    ag_en[0] = 1; ag_ops[0] = 1; st_fix = 1; st_fa = 0; st_fb = 3;
    run("t4", 200);
    check("t4_a_high", 64'(a_hi), 64'd1);
    check("t4_b_high", 64'(b_hi), 64'd4);
    check("t4_nops", 64'(grant_log.size()), 64'd1);

    // 5: reset while waiting on the unit, then req2 alone
    do_reset();
    ag_en[0] = 1; ag_ops[0] = 1; st_zmax = 10;
    begin
      int c = 0;
      while (!m_waitz && c < 200) begin step(); c++; end
      check("t5_reach_waitz", 64'(m_waitz), 64'd1);
    end
    do_reset();
    ag_en[2] = 1; ag_ops[2] = 1;
    run("t5", 200);
    check("t5_grant2", 64'(grant_log.size() == 1 ? grant_log[0] : -1), 64'd2);

    // 6: spurious resp_ack[2] and req_stb[0] during RESP for req1
    do_reset();
    for (int i = 0; i < N; i++) ag_en[i] = 1;
    ag_ops[1] = 1; ag_dly[1] = 6; spur_div = 1;
    begin
      int c = 0;
      while (!m_resp && c < 200) begin step(); c++; end
      check("t6_reach_resp", 64'(m_resp), 64'd1);
    end
    ag_ops[0] = 1;
    run("t6", 300);
    check("t6_nops", 64'(grant_log.size()), 64'd2);
    check("t6_order", 64'({grant_log[0], grant_log[1]}), {32'd1, 32'd0});

    // Random traffic: withdrawals, spurious acks, random unit latency
    do_reset();
    for (int i = 0; i < N; i++) begin ag_en[i] = 1; ag_ops[i] = 25; end
    start_div = 3; spur_div = 4; withdraw = 1; st_zmax = 6;
    run("rand", 20000);
    check("rand_nops", 64'(grant_log.size()), 64'd75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
